// File: rtl/mem_wait_bridge_pkg.sv
// Shared encodings for the memory wait-state bridge.
// Access sizes, FSM states and the latched request bundle.
package mem_wait_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] lo;
    logic       wr;
    logic       err;
  } req_t;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane logic: enables, write replication,
// read steering with zero-extension and misalign detect.
module mem_lane_steer
  import mem_wait_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext,
  output logic        mis
);

  logic is_b;
  logic is_h;

  assign is_b = (size == SZ_BYTE);
  assign is_h = (size == SZ_HALF);

  always_comb begin
    be   = 4'hf;
    wrep = wdata;
    rext = rdata;
    mis  = 1'b0;
    unique case (1'b1)
      is_b: begin
        be   = 4'b0001 << lo;
        wrep = {4{wdata[7:0]}};
        rext = {24'h0, rdata[{lo, 3'b000} +: 8]};
      end
      is_h: begin
        be   = lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
        rext = {16'h0,
                lo[1] ? rdata[31:16] : rdata[15:0]};
        mis  = lo[0];
      end
      default: begin
        be   = 4'hf;
        wrep = wdata;
        rext = rdata;
        mis  = |lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_wait_bridge.sv
// Core-to-RAM bridge: one outstanding access with
// programmable wait states and a one-cycle ready pulse.
module mem_wait_bridge
  import mem_wait_bridge_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MEM_AW      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       ram_data_in,
  input  logic [1:0]        data_size,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  output logic [31:0]       ram_data_into_mcu,
  output logic              ram_ready,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  state_e            state_d;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              idle;
  logic              accept;
  logic [1:0]        st_size;
  logic [1:0]        st_lo;
  logic [3:0]        st_be;
  logic [31:0]       st_wrep;
  logic [31:0]       st_rext;
  logic              st_mis;
  logic              mem_we_q;
  logic [3:0]        mem_be_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rdata_q;
  logic              unused_addr;

  assign unused_addr = &{1'b0, address[31:MEM_AW+2]};

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & cs & (we | oe);

  // IDLE looks at the live request, later states at the latched one
  assign st_size = idle ? data_size : req_q.size;
  assign st_lo   = idle ? address[1:0] : req_q.lo;

  mem_lane_steer u_steer (
    .size  (st_size),
    .lo    (st_lo),
    .wdata (ram_data_in),
    .rdata (mem_rdata),
    .be    (st_be),
    .wrep  (st_wrep),
    .rext  (st_rext),
    .mis   (st_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = st_mis ? S_DONE : S_ISSUE;
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (WAIT_STATES > 0) state_d = S_WAIT;
        else                 state_d = S_DONE;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        req_q.size <= data_size;
        req_q.lo   <= address[1:0];
        req_q.wr   <= we;
        req_q.err  <= st_mis;
        // rejected accesses leave the RAM port untouched
        if (!st_mis) begin
          mem_we_q    <= we;
          mem_be_q    <= st_be;
          mem_addr_q  <= address[MEM_AW+1:2];
          mem_wdata_q <= st_wrep;
        end
      end
      if (state_q == S_CAPTURE) begin
        if (!req_q.wr) rdata_q <= st_rext;
        cnt_q <= CNT_W'(WAIT_STATES);
      end
      if (state_q == S_WAIT) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign mem_en            = (state_q == S_ISSUE);
  assign mem_we            = mem_we_q;
  assign mem_be            = mem_be_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign ram_data_into_mcu = rdata_q;
  assign ram_ready         = (state_q == S_DONE);
  assign err               = ram_ready & req_q.err;
  assign busy              = ~idle;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench: three bridges (0/1/15 wait states)
// share stimulus, each with its own RAM model.
module tb_mem_wait_bridge;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdat;
  logic [1:0]  size;
  logic        cs, we, oe;

  logic [31:0] q_a, q_b, q_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        er_a, er_b, er_c;
  logic        bsy_a, bsy_b, bsy_c;
  logic        en_a, en_b, en_c;
  logic        mwe_a, mwe_b, mwe_c;
  logic [3:0]  be_a, be_b, be_c;
  logic [13:0] ma_a, ma_b, ma_c;
  logic [31:0] wd_a, wd_b, wd_c;
  logic [31:0] rd_a, rd_b, rd_c;

  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic [31:0] ram_c [0:255];

  int total = 0;
  int bad = 0;
  int          lat [3];
  logic [31:0] dat [3];
  logic        ers [3];

  always #5 clk = ~clk;

  mem_wait_bridge #(.WAIT_STATES(1), .MEM_AW(14)) d_a (
    .clk(clk), .rst(rst), .address(address),
    .ram_data_in(wdat), .data_size(size),
    .cs(cs), .we(we), .oe(oe),
    .ram_data_into_mcu(q_a), .ram_ready(rdy_a),
    .err(er_a), .busy(bsy_a), .mem_en(en_a),
    .mem_we(mwe_a), .mem_be(be_a), .mem_addr(ma_a),
    .mem_wdata(wd_a), .mem_rdata(rd_a));

  mem_wait_bridge #(.WAIT_STATES(0), .MEM_AW(14)) d_b (
    .clk(clk), .rst(rst), .address(address),
    .ram_data_in(wdat), .data_size(size),
    .cs(cs), .we(we), .oe(oe),
    .ram_data_into_mcu(q_b), .ram_ready(rdy_b),
    .err(er_b), .busy(bsy_b), .mem_en(en_b),
    .mem_we(mwe_b), .mem_be(be_b), .mem_addr(ma_b),
    .mem_wdata(wd_b), .mem_rdata(rd_b));

  mem_wait_bridge #(.WAIT_STATES(15), .MEM_AW(14)) d_c (
    .clk(clk), .rst(rst), .address(address),
    .ram_data_in(wdat), .data_size(size),
    .cs(cs), .we(we), .oe(oe),
    .ram_data_into_mcu(q_c), .ram_ready(rdy_c),
    .err(er_c), .busy(bsy_c), .mem_en(en_c),
    .mem_we(mwe_c), .mem_be(be_c), .mem_addr(ma_c),
    .mem_wdata(wd_c), .mem_rdata(rd_c));

  always @(posedge clk) begin
    if (en_a) begin
      if (mwe_a) begin
        for (int b = 0; b < 4; b++)
          if (be_a[b])
            ram_a[ma_a[7:0]][8*b +: 8] <= wd_a[8*b +: 8];
      end else rd_a <= ram_a[ma_a[7:0]];
    end
    if (en_b) begin
      if (mwe_b) begin
        for (int b = 0; b < 4; b++)
          if (be_b[b])
            ram_b[ma_b[7:0]][8*b +: 8] <= wd_b[8*b +: 8];
      end else rd_b <= ram_b[ma_b[7:0]];
    end
    if (en_c) begin
      if (mwe_c) begin
        for (int b = 0; b < 4; b++)
          if (be_c[b])
            ram_c[ma_c[7:0]][8*b +: 8] <= wd_c[8*b +: 8];
      end else rd_c <= ram_c[ma_c[7:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((bsy_a | bsy_b | bsy_c) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100)
      chk("idle_to", {29'b0, bsy_c, bsy_b, bsy_a}, 0);
  endtask

  // returns #1 after the accept edge, i.e. in cycle T+1
  task automatic req(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [1:0] s,
                     input logic w);
    wait_idle();
    address = a;
    wdat = d;
    size = s;
    we = w;
    oe = ~w;
    cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
    we = 1'b0;
    oe = 1'b0;
  endtask

  task automatic lat_all();
    lat = '{0, 0, 0};
    for (int n = 1; n <= 40; n++) begin
      if (rdy_a && lat[0] == 0) begin
        lat[0] = n; dat[0] = q_a; ers[0] = er_a;
      end
      if (rdy_b && lat[1] == 0) begin
        lat[1] = n; dat[1] = q_b; ers[1] = er_b;
      end
      if (rdy_c && lat[2] == 0) begin
        lat[2] = n; dat[2] = q_c; ers[2] = er_c;
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0)
        break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fin(input string t,
                     input logic [31:0] d,
                     input int l1, input int l0,
                     input int l15, input logic e);
    lat_all();
    chk({t, "_lat1"}, lat[0], l1);
    chk({t, "_lat0"}, lat[1], l0);
    chk({t, "_lat15"}, lat[2], l15);
    chk({t, "_dat1"}, dat[0], d);
    chk({t, "_dat0"}, dat[1], d);
    chk({t, "_dat15"}, dat[2], d);
    chk({t, "_err1"}, {31'b0, ers[0]}, {31'b0, e});
    chk({t, "_err15"}, {31'b0, ers[2]}, {31'b0, e});
  endtask

  int pb [3];
  int rc [3];
  int t1 [3];
  int t2 [3];

  initial begin
    rst = 1'b0;
    address = '0;
    wdat = '0;
    size = SW;
    cs = 1'b0;
    we = 1'b0;
    oe = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
      ram_c[i] = '0;
    end
    ram_a[16] = 32'hDEADBEEF;
    ram_b[16] = 32'hDEADBEEF;
    ram_c[16] = 32'hDEADBEEF;

    #2;
    chk("rst_ctl",
        {rdy_a, er_a, bsy_a, en_a, mwe_a, be_a}, 0);
    chk("rst_addr", {18'b0, ma_a}, 0);
    chk("rst_wd", wd_a, 0);
    chk("rst_q", q_a, 0);
    @(negedge clk);
    rst = 1'b1;

    req(32'h40, 0, SW, 1'b0);
    chk("wr_en", {31'b0, en_a}, 1);
    chk("wr_addr", {18'b0, ma_a}, 32'h10);
    chk("wr_we", {31'b0, mwe_a}, 0);
    chk("wr_be", {28'b0, be_a}, 4'hf);
    fin("wrd", 32'hDEADBEEF, 4, 3, 18, 1'b0);

    req(32'h43, 32'h000000A5, SB, 1'b1);
    chk("bw_be", {28'b0, be_a}, 4'b1000);
    chk("bw_wd", wd_a, 32'hA5A5A5A5);
    chk("bw_we", {31'b0, mwe_a}, 1);
    chk("bw_en", {31'b0, en_a}, 1);
    fin("bw", 32'hDEADBEEF, 4, 3, 18, 1'b0);

    req(32'h40, 0, SW, 1'b0);
    fin("rb", 32'hA5ADBEEF, 4, 3, 18, 1'b0);

    req(32'h42, 0, SH, 1'b0);
    chk("hr_be", {28'b0, be_a}, 4'b1100);
    fin("hr", 32'h0000A5AD, 4, 3, 18, 1'b0);

    req(32'h41, 0, SB, 1'b0);
    chk("br_be", {28'b0, be_a}, 4'b0010);
    fin("br", 32'h000000BE, 4, 3, 18, 1'b0);

    req(32'h44, 32'hFFFF1234, SH, 1'b1);
    chk("hw_wd", wd_a, 32'h12341234);
    chk("hw_be", {28'b0, be_a}, 4'b0011);
    chk("hw_addr", {18'b0, ma_a}, 32'h11);
    fin("hw", 32'h000000BE, 4, 3, 18, 1'b0);

    req(32'h44, 0, SW, 1'b0);
    fin("hwr", 32'h00001234, 4, 3, 18, 1'b0);

    req(32'h42, 0, SW, 1'b0);
    chk("mw_en", {31'b0, en_a}, 0);
    chk("mw_addr", {18'b0, ma_a}, 32'h11);
    fin("mw", 32'h00001234, 1, 1, 1, 1'b1);

    req(32'h41, 0, SH, 1'b0);
    chk("mh_en", {31'b0, en_a}, 0);
    fin("mh", 32'h00001234, 1, 1, 1, 1'b1);

    req(32'h0001_0040, 0, SW, 1'b0);
    chk("wrap_addr", {18'b0, ma_a}, 32'h10);
    fin("wrap", 32'hA5ADBEEF, 4, 3, 18, 1'b0);

    req(32'h42, 0, 2'b11, 1'b0);
    fin("s3m", 32'hA5ADBEEF, 1, 1, 1, 1'b1);

    wait_idle();
    address = 32'h48;
    size = SW;
    oe = 1'b1;
    cs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pb[k] = 0; rc[k] = 0; t1[k] = 0; t2[k] = 0;
    end
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      we = c[0];
      wdat = c;
      if (bsy_a && pb[0] == 0) begin
        rc[0]++;
        if (rc[0] == 2) t1[0] = c;
        if (rc[0] == 3) t2[0] = c;
      end
      if (bsy_b && pb[1] == 0) begin
        rc[1]++;
        if (rc[1] == 2) t1[1] = c;
        if (rc[1] == 3) t2[1] = c;
      end
      if (bsy_c && pb[2] == 0) begin
        rc[2]++;
        if (rc[2] == 2) t1[2] = c;
        if (rc[2] == 3) t2[2] = c;
      end
      pb[0] = int'(bsy_a);
      pb[1] = int'(bsy_b);
      pb[2] = int'(bsy_c);
    end
    cs = 1'b0;
    we = 1'b0;
    oe = 1'b0;
    chk("b2b_p1", t2[0] - t1[0], 5);
    chk("b2b_p0", t2[1] - t1[1], 4);
    chk("b2b_p15", t2[2] - t1[2], 19);
    chk("b2b_n15", rc[2] >= 3, 1);

    req(32'h40, 0, SW, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rw_busy", {31'b0, bsy_a}, 1);
    chk("rw_rdy", {31'b0, rdy_a}, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ra_ctl",
        {rdy_a, er_a, bsy_a, en_a, mwe_a, be_a}, 0);
    chk("ra_addr", {18'b0, ma_a}, 0);
    chk("ra_wd", wd_a, 0);
    chk("ra_q", q_a, 0);
    chk("ra_b15", {31'b0, bsy_c}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("ra_hold", {30'b0, rdy_a, rdy_c}, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    req(32'h40, 0, SW, 1'b0);
    fin("post", 32'hA5ADBEEF, 4, 3, 18, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
